// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: one-hot opcodes, FSM states and flag bit positions
// shared by alu_seq and alu_core.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b1000;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: stateless N-bit add/sub/and/or with op_err for non-one-hot ops.
// Flag logic exists only when ALU_SEQ_FLAGS_EN is defined.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic carry;
    logic ovf;

    // Carry derived from the modulo result: add wraps iff result < a.
    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (op)
            OP_ADD: begin
                carry = result < a;
                ovf   = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            OP_SUB: begin
                carry = a >= b;
                ovf   = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            default: ;
        endcase
        flags         = 4'b0000;
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[N-1];
        flags[FLAG_Z] = (result == '0);
    end
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready wrapper around alu_core with IDLE/EXEC/HOLD FSM.
// Define ALU_SEQ_FLAGS_EN to register {V,C,N,Z}; otherwise flags is 0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         op_err
);

    state_t       state;
    logic [3:0]   op_lat;
    logic [N-1:0] a_lat;
    logic [N-1:0] b_lat;
    logic [N-1:0] core_result;
    logic [3:0]   core_flags;
    logic         core_err;

    alu_core #(.N(N)) u_core (
        .op     (op_lat),
        .a      (a_lat),
        .b      (b_lat),
        .result (core_result),
        .flags  (core_flags),
        .err    (core_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            op_err    <= 1'b0;
            op_lat    <= 4'b0000;
            a_lat     <= '0;
            b_lat     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            flags     <= 4'b0000;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_lat   <= op;
                        a_lat    <= a;
                        b_lat    <= b;
                        in_ready <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result    <= core_result;
                    op_err    <= core_err;
`ifdef ALU_SEQ_FLAGS_EN
                    flags     <= core_flags;
`endif
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef ALU_SEQ_FLAGS_EN
    assign flags = core_flags;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue scoreboard
// and an independent output monitor.
module tb_alu_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         op_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic was_valid = 1'b0;

    typedef struct {
        logic [N-1:0] r;
        logic [3:0]   f;
        logic         e;
        int           acc;
    } exp_t;

    exp_t q[$];

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] r, input logic [3:0] f,
                                input logic e);
        exp_t x;
        x.r   = r;
        x.e   = e;
        x.acc = 0;
`ifdef ALU_SEQ_FLAGS_EN
        x.f = f;
`else
        x.f = 4'b0000;
`endif
        return x;
    endfunction

    // Monitor: compares every presented output against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual out_valid=1 required 0");
            end else begin
                if (!was_valid) chk("latency", cyc - q[0].acc, 2);
                chk("result", {24'd0, result}, {24'd0, q[0].r});
                chk("flags", {28'd0, flags}, {28'd0, q[0].f});
                chk("op_err", {31'd0, op_err}, {31'd0, q[0].e});
                chk("in_ready_busy", {31'd0, in_ready}, 0);
                if (out_ready) void'(q.pop_front());
            end
        end
        was_valid = out_valid && !out_ready && !reset;
    end

    task automatic send(input logic [3:0] o, input logic [N-1:0] x,
                        input logic [N-1:0] y, input exp_t e);
        int n = 0;
        @(negedge clk);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.acc = cyc;
        q.push_back(e);
        #1;
        in_valid = 1'b0;
        a        = ~x;
        b        = ~y;
        op       = 4'b0001;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'b0000;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_flags", {28'd0, flags}, 0);
        chk("rst_op_err", {31'd0, op_err}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        send(4'b0001, 8'hFF, 8'h01, mk(8'h00, 4'b0101, 1'b0));
        send(4'b0001, 8'h7F, 8'h01, mk(8'h80, 4'b1010, 1'b0));
        send(4'b0010, 8'h05, 8'h07, mk(8'hFE, 4'b0010, 1'b0));
        send(4'b0011, 8'h12, 8'h34, mk(8'h00, 4'b0001, 1'b1));
        send(4'b0100, 8'hF0, 8'h3C, mk(8'h30, 4'b0000, 1'b0));
        send(4'b1000, 8'hF0, 8'h0F, mk(8'hFF, 4'b0010, 1'b0));
        send(4'b0000, 8'h01, 8'h01, mk(8'h00, 4'b0001, 1'b1));
        send(4'b0010, 8'h80, 8'h01, mk(8'h7F, 4'b1100, 1'b0));
        send(4'b0010, 8'h33, 8'h33, mk(8'h00, 4'b0101, 1'b0));
        send(4'b1111, 8'hAA, 8'h55, mk(8'h00, 4'b0001, 1'b1));
        send(4'b0001, 8'h80, 8'h80, mk(8'h00, 4'b1101, 1'b0));
        drain();

        // Back-pressure: result must hold while inputs churn.
        out_ready = 1'b0;
        send(4'b0001, 8'h12, 8'h34, mk(8'h46, 4'b0000, 1'b0));
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", {31'd0, out_valid}, 1);
        repeat (5) begin
            @(negedge clk);
            a        = N'($urandom);
            b        = N'($urandom);
            op       = 4'b0100;
            in_valid = ~in_valid;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_after_hold", {31'd0, in_ready}, 1);
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        // Reset while in EXEC discards the pending result.
        @(negedge clk);
        op       = 4'b0001;
        a        = 8'h20;
        b        = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_result", {24'd0, result}, 0);
        chk("abort_flags", {28'd0, flags}, 0);
        chk("abort_op_err", {31'd0, op_err}, 0);
        chk("abort_in_ready", {31'd0, in_ready}, 1);
        repeat (4) @(negedge clk);

        send(4'b1000, 8'h00, 8'h00, mk(8'h00, 4'b0001, 1'b0));
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
